// File: rtl/calc_pkg.sv
// Shared encodings for the BCD calculator datapath: command codes,
// operator codes, one-hot operator constants and operand sizing.
package calc_pkg;

  localparam int DIGITS = 4;
  localparam int OPND_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    SAVE_IDLE = 2'b00,
    SAVE_OP1  = 2'b01,
    SAVE_OPR  = 2'b10,
    SAVE_OP2  = 2'b11
  } save_cmd_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_code_t;

  localparam logic [3:0] ONEHOT_NONE = 4'b0000;
  localparam logic [3:0] ONEHOT_ADD  = 4'b0001;
  localparam logic [3:0] ONEHOT_SUB  = 4'b0010;
  localparam logic [3:0] ONEHOT_MUL  = 4'b0100;
  localparam logic [3:0] ONEHOT_DIV  = 4'b1000;

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    logic [3:0] code;
    code = ONEHOT_NONE;
    case (op)
      OP_ADD:  code = ONEHOT_ADD;
      OP_SUB:  code = ONEHOT_SUB;
      OP_MUL:  code = ONEHOT_MUL;
      OP_DIV:  code = ONEHOT_DIV;
      default: code = ONEHOT_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/memory_bcd_shift_reg.sv
// BCD operand register: clear, parallel load, or shift in one digit at the
// least significant end. Non-BCD digits are dropped and the value holds.
module bcd_shift_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  shift,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   value
);

  logic [4*DIGITS-1:0] value_next;

  // Clear beats load beats shift; the oldest digit falls off the top on shift.
  always_comb begin
    value_next = value;
    if (clear) begin
      value_next = '0;
    end else if (load) begin
      value_next = load_value;
    end else if (shift && is_bcd_digit(digit)) begin
      value_next = {value[4*DIGITS-5:0], digit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/memory.sv
// Operand/operator storage for the BCD calculator: accumulates keypad digits
// into two operands, latches the operator one-hot, reloads save1 on equals.
module memory
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            num,
  input  logic [4*DIGITS-1:0]   res,
  input  logic [1:0]            operator,
  input  logic                  clear_enable,
  input  logic                  equ_enable,
  input  logic [1:0]            save_enable,
  input  logic                  op_enable,
  output logic [4*DIGITS-1:0]   save1,
  output logic [4*DIGITS-1:0]   save2,
  output logic [3:0]            op_out
);

  logic       shift1;
  logic       shift2;
  logic       op_latch;
  logic       load1;
  logic       clear2;
  logic [3:0] op_next;

  // Command priority: clear, then equals, then digit/operator commands.
  always_comb begin
    shift1   = 1'b0;
    shift2   = 1'b0;
    op_latch = 1'b0;
    load1    = 1'b0;
    clear2   = 1'b0;
    if (clear_enable) begin
      clear2 = 1'b1;
    end else if (equ_enable) begin
      load1  = 1'b1;
      clear2 = 1'b1;
    end else begin
      shift1   = (save_enable == SAVE_OP1);
      shift2   = (save_enable == SAVE_OP2);
      op_latch = (save_enable == SAVE_OPR) || op_enable;
    end
  end

  always_comb begin
    op_next = op_out;
    if (clear_enable) begin
      op_next = ONEHOT_NONE;
    end else if (op_latch) begin
      op_next = op_onehot(operator);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_out <= ONEHOT_NONE;
    end else begin
      op_out <= op_next;
    end
  end

  bcd_shift_reg #(.DIGITS(DIGITS)) u_save1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_enable),
    .load       (load1),
    .load_value (res),
    .shift      (shift1),
    .digit      (num),
    .value      (save1)
  );

  bcd_shift_reg #(.DIGITS(DIGITS)) u_save2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear2),
    .load       (1'b0),
    .load_value ('0),
    .shift      (shift2),
    .digit      (num),
    .value      (save2)
  );

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus pushes hand-computed expectations,
// a monitor pops and compares after each rising edge.
module tb_memory;

  logic        clk;
  logic        rst_n;
  logic [3:0]  num;
  logic [15:0] res;
  logic [1:0]  operator;
  logic        clear_enable;
  logic        equ_enable;
  logic [1:0]  save_enable;
  logic        op_enable;
  logic [15:0] save1;
  logic [15:0] save2;
  logic [3:0]  op_out;

  typedef struct {
    string       name;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [3:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   compared_count = 0;
  int   mismatch_count = 0;

  memory #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .num          (num),
    .res          (res),
    .operator     (operator),
    .clear_enable (clear_enable),
    .equ_enable   (equ_enable),
    .save_enable  (save_enable),
    .op_enable    (op_enable),
    .save1        (save1),
    .save2        (save2),
    .op_out       (op_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [3:0] eo);
    compared_count++;
    if (save1 !== e1 || save2 !== e2 || op_out !== eo) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got save1=%h save2=%h op_out=%b, want save1=%h save2=%h op_out=%b",
               name, save1, save2, op_out, e1, e2, eo);
    end
  endtask

  task automatic drive_idle();
    num = 4'd0; res = 16'h0000; operator = 2'b00;
    clear_enable = 1'b0; equ_enable = 1'b0; save_enable = 2'b00; op_enable = 1'b0;
  endtask

  // Drives one cycle of inputs on the falling edge and queues the state
  // expected after the following rising edge.
  task automatic apply_stimulus(input string name, input logic [1:0] se,
                                input logic [3:0] n, input logic [1:0] opr,
                                input logic ope, input logic clr, input logic equ,
                                input logic [15:0] r, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [3:0] eo);
    exp_t e;
    @(negedge clk);
    save_enable = se; num = n; operator = opr; op_enable = ope;
    clear_enable = clr; equ_enable = equ; res = r;
    e.name = name; e.s1 = e1; e.s2 = e2; e.op = eo;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output(e.name, e.s1, e.s2, e.op);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    mismatch_count++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int waited;
    drive_idle();
    rst_n = 1'b0;
    #3;
    check_output("reset_initial", 16'h0000, 16'h0000, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("digit1",  2'b01, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0001, 16'h0000, 4'b0000);
    apply_stimulus("digit2",  2'b01, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0000, 4'b0000);
    apply_stimulus("digit3",  2'b01, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0123, 16'h0000, 4'b0000);
    apply_stimulus("digit4",  2'b01, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1234, 16'h0000, 4'b0000);
    apply_stimulus("digit5",  2'b01, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h2345, 16'h0000, 4'b0000);
    apply_stimulus("digit6",  2'b01, 4'd6, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h3456, 16'h0000, 4'b0000);
    apply_stimulus("latch_sub", 2'b00, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 16'h3456, 16'h0000, 4'b0010);

    // Asynchronous reset pulse well clear of both clock edges.
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1 check_output("reset_midcycle", 16'h0000, 16'h0000, 4'b0000);
    #1 rst_n = 1'b1;

    apply_stimulus("idle_after_reset", 2'b00, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0000, 16'h0000, 4'b0000);
    apply_stimulus("restart1", 2'b01, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0001, 16'h0000, 4'b0000);
    apply_stimulus("restart2", 2'b01, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0000, 4'b0000);
    apply_stimulus("opr_div",  2'b10, 4'd3, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0000, 4'b1000);
    apply_stimulus("open_sub", 2'b00, 4'd3, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0000, 4'b0010);
    apply_stimulus("op2_digit5", 2'b11, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0005, 4'b0010);
    apply_stimulus("hold_idle", 2'b00, 4'd8, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 16'h0005, 4'b0010);
    apply_stimulus("equals",   2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b0010);
    apply_stimulus("op2_digit3", 2'b11, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1234, 16'h0003, 4'b0010);
    apply_stimulus("equ_beats_save", 2'b01, 4'd7, 2'b10, 1'b1, 1'b0, 1'b1, 16'h0042, 16'h0042, 16'h0000, 4'b0010);
    apply_stimulus("invalid_digit_op", 2'b01, 4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0042, 16'h0000, 4'b0100);
    apply_stimulus("invalid_digit2", 2'b11, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0042, 16'h0000, 4'b0100);
    apply_stimulus("digit_and_op", 2'b11, 4'd9, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0042, 16'h0009, 4'b0001);
    apply_stimulus("op1_digit_and_op", 2'b01, 4'd8, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0428, 16'h0009, 4'b1000);
    apply_stimulus("clear_c1", 2'b11, 4'd5, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0000, 16'h0000, 4'b0000);
    apply_stimulus("clear_c2", 2'b11, 4'd5, 2'b01, 1'b1, 1'b1, 1'b1, 16'h7777, 16'h0000, 16'h0000, 4'b0000);
    apply_stimulus("clear_c3", 2'b11, 4'd5, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 16'h0000, 4'b0000);
    apply_stimulus("after_clear", 2'b11, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 16'h0005, 4'b0000);
    apply_stimulus("opr_mul", 2'b10, 4'd1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 16'h0005, 4'b0100);

    @(negedge clk);
    drive_idle();
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      mismatch_count++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Operand/operator storage for the 4-digit BCD calculator datapath.
- Accumulates keypad digits into two 16-bit BCD operand registers (save1, save2) and latches the selected operator as a one-hot code (op_out).
- Loads the ALU result back into save1 on "equals" for chained operations.
- Sits between keypad decoder/control FSM and the arithmetic unit.

Parameters:
- DIGITS, 4, number of BCD digits per operand; operand width = 4*DIGITS = 16.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- num  in  4  keypad digit, BCD 0..9
- res  in  16  result from arithmetic unit, BCD
- operator  in  2  operator select: 00 add, 01 sub, 10 mul, 11 div
- clear_enable  in  1  clear all stored state
- equ_enable  in  1  equals: load res into save1
- save_enable  in  2  00 idle, 01 shift digit into save1, 10 latch operator, 11 shift digit into save2
- op_enable  in  1  latch operator regardless of save_enable
- save1  out  16  first operand, BCD, registered
- save2  out  16  second operand, BCD, registered
- op_out  out  4  one-hot operator, registered: 0001 add, 0010 sub, 0100 mul, 1000 div, 0000 none

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n); reset forces save1=0, save2=0, op_out=0 immediately, independent of clk.
- All outputs come straight from registers; one-cycle latency from a sampled command to the visible output.
- Command priority per rising edge, highest first: clear_enable > equ_enable > save_enable > op_enable.
- clear_enable=1: save1=0, save2=0, op_out=0. While held high, all other commands are ignored every cycle.
- equ_enable=1 (no clear): save1<=res, save2<=0, op_out unchanged.
- save_enable=01: save1 <= {save1[11:0], num}; save2 and op_out unchanged.
  - The most significant digit is discarded on the 5th and later digits (wrap by shift-out).
- save_enable=11: same shift into save2; save1 and op_out unchanged.
- save_enable=10: op_out <= onehot(operator); save1 and save2 unchanged.
- save_enable=00 and op_enable=1: op_out <= onehot(operator).
- save_enable=01/11 together with op_enable=1: perform the digit shift and also latch op_out.
- A digit command with num > 9 is ignored (register holds); an operator latch in the same cycle still occurs.
- No command active: all registers hold.
- Reset asserted mid-sequence: all registers clear at once; accumulation restarts from 0 after release.

Decomposition:
- Shared package calc_pkg:
  - save_enable encodings (SAVE_IDLE=00, SAVE_OP1=01, SAVE_OPR=10, SAVE_OP2=11)
  - operator codes (OP_ADD..OP_DIV)
  - one-hot op_out constants
  - operand width constant (16)
- One small sub-module is natural: bcd_shift_reg (16-bit, load/shift/clear, digit-valid check), instantiated twice for save1 and save2.
- Operator decode and priority logic stay in memory.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> save1=0000, save2=0000, op_out=0000 before the next edge.
- Digit entry: save_enable=01, num=1 then num=2 over two edges -> save1=0x0001 then 0x0012; save2=0000. Five digits 1..5 -> save1=0x2345.
- Clear priority: clear_enable=1 held with save_enable=11, num=5 -> save1=save2=0000, op_out=0000 every cycle. After clear drops, save_enable=11, num=5 -> save2=0x0005.
- Operator latch: save_enable=10, operator=11 -> op_out=1000; save1/save2 unchanged. op_enable=1, save_enable=00, operator=01 -> op_out=0010.
- Equals: save1=0x0012, save2=0x0005, res=0x1234, equ_enable=1 -> save1=0x1234, save2=0000, op_out retained. equ_enable together with save_enable=01 -> equ wins.
- Invalid digit: save_enable=01, num=4'hA -> save1 unchanged. Same cycle op_enable=1, operator=10 -> op_out=0100.
